// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: instruction field positions, opcodes, control-bit
// indices and the decoded-instruction payload carried through decode.
package cpu_pkg;

    localparam int unsigned INSTR_W  = 16;
    localparam int unsigned DEC_PC_W = 16;
    localparam int unsigned OPC_W    = 4;
    localparam int unsigned REG_W    = 3;
    localparam int unsigned FUNCT_W  = 3;
    localparam int unsigned IMM_W    = 6;
    localparam int unsigned CTRL_W   = 5;

    localparam int unsigned OPC_LSB   = 12;
    localparam int unsigned RS_LSB    = 9;
    localparam int unsigned RT_LSB    = 6;
    localparam int unsigned RD_LSB    = 3;
    localparam int unsigned FUNCT_LSB = 0;
    localparam int unsigned IMM_LSB   = 0;

    localparam logic [OPC_W-1:0] OP_RTYPE = 4'd0;
    localparam logic [OPC_W-1:0] OP_ADDI  = 4'd1;
    localparam logic [OPC_W-1:0] OP_LW    = 4'd2;
    localparam logic [OPC_W-1:0] OP_SW    = 4'd3;
    localparam logic [OPC_W-1:0] OP_BEQ   = 4'd4;

    localparam int unsigned CTRL_REG_WRITE   = 4;
    localparam int unsigned CTRL_MEM_READ    = 3;
    localparam int unsigned CTRL_MEM_WRITE   = 2;
    localparam int unsigned CTRL_BRANCH      = 1;
    localparam int unsigned CTRL_ALU_SRC_IMM = 0;

    typedef struct packed {
        logic [DEC_PC_W-1:0] pc;
        logic [OPC_W-1:0]    opcode;
        logic [REG_W-1:0]    rs;
        logic [REG_W-1:0]    rt;
        logic [REG_W-1:0]    rd;
        logic [FUNCT_W-1:0]  funct;
        logic [IMM_W-1:0]    imm6;
        logic [CTRL_W-1:0]   ctrl;
        logic                illegal;
    } dec_instr_t;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

    // Opcodes that actually read rt as a source register.
    function automatic logic reads_rt(input logic [OPC_W-1:0] opcode);
        return (opcode == OP_RTYPE) || (opcode == OP_SW) || (opcode == OP_BEQ);
    endfunction

endpackage

// File: rtl/decode_skid_stage_if.sv
// Fetch-side, execute-side and hazard signals of the decode stage.
interface decode_skid_stage_if
    import cpu_pkg::*;
#(
    parameter int unsigned PC_W = 16
) ();

    logic               flush;
    logic               in_valid;
    logic               in_ready;
    logic [INSTR_W-1:0] in_instr;
    logic [PC_W-1:0]    in_pc;
    logic               ex_mem_read;
    logic [REG_W-1:0]   ex_rd;
    logic               out_valid;
    logic               out_ready;
    logic [PC_W-1:0]    out_pc;
    logic [OPC_W-1:0]   out_opcode;
    logic [REG_W-1:0]   out_rs;
    logic [REG_W-1:0]   out_rt;
    logic [REG_W-1:0]   out_rd;
    logic [FUNCT_W-1:0] out_funct;
    logic [IMM_W-1:0]   out_imm6;
    logic               out_reg_write;
    logic               out_mem_read;
    logic               out_mem_write;
    logic               out_branch;
    logic               out_alu_src_imm;
    logic               out_illegal;

    // Environment: fetch, execute and the hazard/flush sources.
    modport master (
        output flush, in_valid, in_instr, in_pc, ex_mem_read, ex_rd, out_ready,
        input  in_ready, out_valid, out_pc, out_opcode, out_rs, out_rt, out_rd,
               out_funct, out_imm6, out_reg_write, out_mem_read, out_mem_write,
               out_branch, out_alu_src_imm, out_illegal
    );

    // The decode stage itself.
    modport slave (
        input  flush, in_valid, in_instr, in_pc, ex_mem_read, ex_rd, out_ready,
        output in_ready, out_valid, out_pc, out_opcode, out_rs, out_rt, out_rd,
               out_funct, out_imm6, out_reg_write, out_mem_read, out_mem_write,
               out_branch, out_alu_src_imm, out_illegal
    );

endinterface

// File: rtl/instr_decoder.sv
// Combinational split of a 16-bit instruction into fields and control bits.
module instr_decoder
    import cpu_pkg::*;
(
    input  logic [INSTR_W-1:0]  instr,
    input  logic [DEC_PC_W-1:0] pc,
    output dec_instr_t          dec
);

    logic [OPC_W-1:0] opcode;

    assign opcode = instr[OPC_LSB +: OPC_W];

    always_comb begin
        dec         = '0;
        dec.pc      = pc;
        dec.opcode  = opcode;
        dec.rs      = instr[RS_LSB +: REG_W];
        dec.rt      = instr[RT_LSB +: REG_W];
        dec.rd      = instr[RD_LSB +: REG_W];
        dec.funct   = instr[FUNCT_LSB +: FUNCT_W];
        dec.imm6    = instr[IMM_LSB +: IMM_W];

        case (opcode)
            OP_RTYPE: begin
                dec.ctrl[CTRL_REG_WRITE] = 1'b1;
            end
            OP_ADDI: begin
                dec.ctrl[CTRL_REG_WRITE]   = 1'b1;
                dec.ctrl[CTRL_ALU_SRC_IMM] = 1'b1;
            end
            OP_LW: begin
                dec.ctrl[CTRL_REG_WRITE]   = 1'b1;
                dec.ctrl[CTRL_MEM_READ]    = 1'b1;
                dec.ctrl[CTRL_ALU_SRC_IMM] = 1'b1;
            end
            OP_SW: begin
                dec.ctrl[CTRL_MEM_WRITE]   = 1'b1;
                dec.ctrl[CTRL_ALU_SRC_IMM] = 1'b1;
            end
            OP_BEQ: begin
                dec.ctrl[CTRL_BRANCH] = 1'b1;
            end
            default: begin
                dec.illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/decode_skid_stage.sv
// Decode stage: decodes fetched instructions into a head+skid buffer and
// presents the head to execute, stalling on load-use hazards.
module decode_skid_stage
    import cpu_pkg::*;
#(
    parameter int unsigned PC_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    decode_skid_stage_if.slave bus
);

    occ_e       state;
    occ_e       state_d;
    dec_instr_t head;
    dec_instr_t head_d;
    dec_instr_t skid;
    dec_instr_t skid_d;
    dec_instr_t in_dec;
    logic       in_ready_q;
    logic       in_ready_d;
    logic       head_valid;
    logic       hazard;
    logic       out_valid_c;
    logic       accept;
    logic       pop;

    instr_decoder u_decoder (
        .instr (bus.in_instr),
        .pc    (DEC_PC_W'(bus.in_pc)),
        .dec   (in_dec)
    );

    // Load-use stall: the load in execute writes a register the head reads.
    assign head_valid = (state != OCC_EMPTY);
    assign hazard     = head_valid && bus.ex_mem_read && (bus.ex_rd != '0)
                     && ((bus.ex_rd == head.rs)
                         || ((bus.ex_rd == head.rt) && reads_rt(head.opcode)));

    assign out_valid_c = head_valid && !hazard;
    assign accept      = bus.in_valid && in_ready_q;
    assign pop         = out_valid_c && bus.out_ready;

    // Occupancy next-state and buffer moves; flush overrides everything.
    always_comb begin
        state_d = state;
        head_d  = head;
        skid_d  = skid;

        if (bus.flush) begin
            state_d = OCC_EMPTY;
        end else begin
            case (state)
                OCC_EMPTY: begin
                    if (accept) begin
                        state_d = OCC_ONE;
                        head_d  = in_dec;
                    end
                end
                OCC_ONE: begin
                    if (accept && !pop) begin
                        state_d = OCC_TWO;
                        skid_d  = in_dec;
                    end else if (accept && pop) begin
                        head_d  = in_dec;
                    end else if (pop) begin
                        state_d = OCC_EMPTY;
                    end
                end
                OCC_TWO: begin
                    if (pop) begin
                        state_d = OCC_ONE;
                        head_d  = skid;
                    end
                end
                default: begin
                    state_d = OCC_EMPTY;
                end
            endcase
        end

        in_ready_d = (state_d != OCC_TWO);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= OCC_EMPTY;
            head       <= '0;
            skid       <= '0;
            in_ready_q <= 1'b0;
        end else begin
            state      <= state_d;
            head       <= head_d;
            skid       <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign bus.in_ready        = in_ready_q;
    assign bus.out_valid       = out_valid_c;
    assign bus.out_pc          = PC_W'(head.pc);
    assign bus.out_opcode      = head.opcode;
    assign bus.out_rs          = head.rs;
    assign bus.out_rt          = head.rt;
    assign bus.out_rd          = head.rd;
    assign bus.out_funct       = head.funct;
    assign bus.out_imm6        = head.imm6;
    assign bus.out_reg_write   = head.ctrl[CTRL_REG_WRITE];
    assign bus.out_mem_read    = head.ctrl[CTRL_MEM_READ];
    assign bus.out_mem_write   = head.ctrl[CTRL_MEM_WRITE];
    assign bus.out_branch      = head.ctrl[CTRL_BRANCH];
    assign bus.out_alu_src_imm = head.ctrl[CTRL_ALU_SRC_IMM];
    assign bus.out_illegal     = head.illegal;

endmodule

// File: doc/decode_skid_stage.md
Name: decode_skid_stage

Overview:
- Instruction-decode pipeline stage directly upstream of sign_extend.
- Accepts fetched 16-bit instructions over a valid/ready handshake and splits them into register fields, a 6-bit immediate and control bits.
- Buffers them in a 2-entry skid buffer and presents one registered decoded instruction to the execute side.
- out_imm6 feeds the sign extender's 6-bit input. Load-use hazards and pipeline flush are handled here.

Parameters:
- PC_W, 16, width of the program counter carried alongside each instruction.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  discard all buffered instructions (taken branch/jump).
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  stage can accept an instruction this cycle.
- in_instr  in  16  instruction word.
- in_pc  in  PC_W  PC of in_instr.
- ex_mem_read  in  1  instruction currently in execute is a load.
- ex_rd  in  3  destination register of that load.
- out_valid  out  1  decoded instruction available.
- out_ready  in  1  execute accepts it.
- out_pc  out  PC_W  PC of the head instruction.
- out_opcode  out  4  instr[15:12].
- out_rs  out  3  instr[11:9].
- out_rt  out  3  instr[8:6].
- out_rd  out  3  instr[5:3].
- out_funct  out  3  instr[2:0].
- out_imm6  out  6  instr[5:0]; sign_extend input.
- out_reg_write, out_mem_read, out_mem_write, out_branch, out_alu_src_imm  out  1 each  control bits.
- out_illegal  out  1  opcode not defined.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n. While rst_n=0, every output register is 0 and in_ready=0. in_ready becomes 1 on the first rising edge after release.
- Opcode decode (reg_write, mem_read, mem_write, branch, alu_src_imm):
  - 0 R-type: 1,0,0,0,0
  - 1 ADDI: 1,0,0,0,1
  - 2 LW: 1,1,0,0,1
  - 3 SW: 0,0,1,0,1
  - 4 BEQ: 0,0,0,1,0
  - 5-15: all 0, illegal=1
- Decode is combinational on in_instr. Decoded fields are stored, not recomputed at the output.
- Buffer: head register plus skid register. State is occupancy EMPTY/ONE/TWO.
- in_ready is a registered output: in_ready = (state != TWO). It never depends combinationally on out_ready.
- Accept = in_valid & in_ready. Pop = out_valid & out_ready.
- Hazard = head valid & ex_mem_read & ex_rd != 0 & (ex_rd == head rs | (ex_rd == head rt & opcode in {0,3,4})).
- out_valid = head valid & !hazard. While hazard=1 nothing pops and all outputs hold.
- Transitions:
  - EMPTY: accept -> ONE; accepted data goes to head.
  - ONE: accept & !pop -> TWO (data to skid). Accept & pop -> ONE (head <= input). Pop only -> EMPTY.
  - TWO: no accept possible. Pop -> ONE; head <= skid.
- Latency: 1 cycle from accept to out_valid when empty. Throughput: 1 per cycle with out_ready held high.
- Flush:
  - Highest priority. Next edge -> EMPTY with out_valid=0 and in_ready=1.
  - An instruction accepted in the flush cycle is dropped.
  - A pop in the flush cycle still counts at execute.
- Ordering: strict FIFO order. No instruction is duplicated or lost except by flush.
- Data hold: outputs hold stable while out_valid & !out_ready. Payload regs are don't-care when not valid. out_valid must be exactly 0 when the stage is empty.
- Reset mid-operation: asynchronous clear to EMPTY. Any buffered instruction is lost.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode constants OP_RTYPE=0, OP_ADDI=1, OP_LW=2, OP_SW=3, OP_BEQ=4;
  - field bit positions;
  - a decoded-instruction struct {pc, opcode, rs, rt, rd, funct, imm6, ctrl[4:0], illegal}.
- Sub-module instr_decoder: purely combinational, 16-bit instruction in, decoded struct out. The skid/FSM logic lives in decode_skid_stage.

Test Plan:
- Reset and single instruction: reset, then in_instr=0x1A7F (ADDI rs=5 rt=1 imm6=0x3F) at pc=0x0010 with out_ready=1. Next cycle requires out_valid=1, out_rs=5, out_rt=1, out_imm6=0x3F, reg_write=1, alu_src_imm=1, out_pc=0x0010.
- Backpressure: stream 0x2000, 0x3000, 0x4000 with out_ready=0. Requires in_ready=0 after 2 accepts and the third held by fetch. Releasing out_ready must deliver exactly 0x2000, 0x3000, 0x4000 in order.
- Load-use hazard: head=0x0250 (R-type rs=1 rt=1), ex_mem_read=1, ex_rd=1. Requires out_valid=0 until ex_mem_read drops, then out_valid=1 with the same fields. With ex_rd=0 there must be no stall.
- Flush with both entries full and in_valid=1: requires out_valid=0 and in_ready=1 next cycle, and the flush-cycle instruction never appears.
- Illegal and streaming: send 0xF123 followed by 0x0000 every cycle with out_ready=1. Requires out_illegal=1 with all control bits 0 for the first, and one output per cycle with no bubbles.
- Async reset mid-stream: pulse rst_n low between clock edges while in TWO. Requires out_valid=0 immediately, and correct operation after release.
